// File: rtl/bsg_gateway_power_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_gateway_power_pkg
//  Description : Shared types and helpers for the gateway power-rail
//                sequencer. Holds the sequencer state encoding and a
//                safe clog2 used to size rail-index vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_gateway_power_pkg;

    // Sequencer states. The 3-bit encoding is shared with software-visible
    // debug taps, so keep the explicit values stable.
    typedef enum logic [2:0] {
        PWR_OFF       = 3'd0,
        PWR_UP_PG     = 3'd1,
        PWR_UP_SETTLE = 3'd2,
        PWR_ON        = 3'd3,
        PWR_DOWN      = 3'd4,
        PWR_FAULT     = 3'd5,
        PWR_OVR       = 3'd6
    } bsg_gateway_power_state_e;

    // clog2 that never returns 0, so a single-rail build still gets a
    // 1-bit index vector instead of a zero-width one.
    function automatic int bsg_safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bsg_gateway_power_pkg
`default_nettype wire

// File: rtl/bsg_sync_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_sync_sync
//  Description : Two-flop synchronizer for a bundle of independent,
//                quasi-static bits entering the oclk domain. Each bit is
//                synchronized on its own; no coherency across bits.
//  Ports       : oclk_i       - destination clock
//                iclk_data_i  - asynchronous input bits
//                oclk_data_o  - synchronized bits (2 oclk edges of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_sync_sync #(
    parameter int width_p = 1
) (
    input  logic               oclk_i,
    input  logic [width_p-1:0] iclk_data_i,
    output logic [width_p-1:0] oclk_data_o
);

    // No reset on purpose: these flops only ever hold a sampled copy of
    // the input and flush themselves within two edges.
    logic [width_p-1:0] r_sync_1;
    logic [width_p-1:0] r_sync_2;

    always_ff @(posedge oclk_i) begin
        r_sync_1 <= iclk_data_i;
        r_sync_2 <= r_sync_1;
    end

    assign oclk_data_o = r_sync_2;

endmodule : bsg_sync_sync
`default_nettype wire

// File: rtl/bsg_gateway_power_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_gateway_power_seq
//  Description : Power-rail sequencer for the gateway FPGA. Enables the
//                ASIC rails one at a time (rail 0 first), waits for each
//                rail's power-good plus a settle delay, and powers down in
//                reverse order. Captures brown-outs and power-good timeouts
//                as a latched fault, and lets the CPU drive the enables
//                directly in override mode.
//  Ports       : clk_i          - sequencer clock
//                reset_n_i      - asynchronous active-low reset
//                power_on_req_i - level request, 1 = up, 0 = down
//                pgood_i        - per-rail power-good (asynchronous)
//                delay_i        - settle cycles after pgood / after disable
//                timeout_i      - max cycles waiting for pgood, 0 = none
//                override_i     - CPU override request
//                override_en_i  - rail enables used in override mode
//                fault_clr_i    - clears a latched fault (with req low)
//                rail_en_o      - registered rail enables
//                busy_o         - ramping up or down
//                all_on_o       - fully powered
//                fault_o        - fault latched
//                fault_rail_o   - index of the rail that caused the fault
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_gateway_power_seq
    import bsg_gateway_power_pkg::*;
#(
    parameter int num_rails_p = 3,
    parameter int cnt_width_p = 16
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    power_on_req_i,
    input  logic [num_rails_p-1:0]                  pgood_i,
    input  logic [cnt_width_p-1:0]                  delay_i,
    input  logic [cnt_width_p-1:0]                  timeout_i,
    input  logic                                    override_i,
    input  logic [num_rails_p-1:0]                  override_en_i,
    input  logic                                    fault_clr_i,
    output logic [num_rails_p-1:0]                  rail_en_o,
    output logic                                    busy_o,
    output logic                                    all_on_o,
    output logic                                    fault_o,
    output logic [bsg_safe_clog2(num_rails_p)-1:0]  fault_rail_o
);

    localparam int                 c_idx_w    = bsg_safe_clog2(num_rails_p);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(num_rails_p - 1);

    // ------------------------------------------------------------------
    // Power-good synchronization
    // ------------------------------------------------------------------
    logic [num_rails_p-1:0] w_pg;

    bsg_sync_sync #(
        .width_p     (num_rails_p)
    ) u_pg_sync (
        .oclk_i      (clk_i),
        .iclk_data_i (pgood_i),
        .oclk_data_o (w_pg)
    );

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    bsg_gateway_power_state_e r_state;
    logic [c_idx_w-1:0]       r_idx;
    logic [cnt_width_p-1:0]   r_cnt;
    logic [num_rails_p-1:0]   r_rail_en;
    logic [c_idx_w-1:0]       r_fault_rail;
    logic                     r_busy;
    logic                     r_all_on;
    logic                     r_fault;

    // ------------------------------------------------------------------
    // Helper terms
    // ------------------------------------------------------------------
    logic                   w_pg_cur;
    logic                   w_timeout_hit;
    logic                   w_delay_hit;
    logic                   w_last_rail;
    logic                   w_first_rail;
    logic [c_idx_w-1:0]     w_idx_inc;
    logic [c_idx_w-1:0]     w_idx_dec;
    logic [cnt_width_p-1:0] w_cnt_inc;
    logic                   w_any_low;
    logic [c_idx_w-1:0]     w_low_idx;

    assign w_pg_cur      = w_pg[r_idx];
    assign w_timeout_hit = (timeout_i != '0) && (r_cnt == timeout_i);
    assign w_delay_hit   = (r_cnt == delay_i);
    assign w_last_rail   = (r_idx == c_last_idx);
    assign w_first_rail  = (r_idx == '0);
    assign w_idx_inc     = r_idx + c_idx_w'(1);
    assign w_idx_dec     = r_idx - c_idx_w'(1);
    assign w_cnt_inc     = r_cnt + cnt_width_p'(1);

    // Lowest-numbered rail whose power-good is missing. Scanning from the
    // top down lets the lowest index overwrite any higher one.
    always_comb begin
        w_any_low = 1'b0;
        w_low_idx = '0;
        for (int i = num_rails_p - 1; i >= 0; i--) begin
            if (!w_pg[i]) begin
                w_any_low = 1'b1;
                w_low_idx = c_idx_w'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    bsg_gateway_power_state_e w_state_n;
    logic [c_idx_w-1:0]       w_idx_n;
    logic [cnt_width_p-1:0]   w_cnt_n;
    logic [num_rails_p-1:0]   w_rail_en_n;
    logic [c_idx_w-1:0]       w_fault_rail_n;

    always_comb begin
        w_state_n      = r_state;
        w_idx_n        = r_idx;
        w_cnt_n        = r_cnt;
        w_rail_en_n    = r_rail_en;
        w_fault_rail_n = r_fault_rail;

        case (r_state)
            PWR_OFF: begin
                w_rail_en_n = '0;
                w_idx_n     = '0;
                w_cnt_n     = '0;
                if (override_i) begin
                    w_state_n   = PWR_OVR;
                    w_rail_en_n = override_en_i;
                end else if (power_on_req_i) begin
                    w_state_n   = PWR_UP_PG;
                    w_rail_en_n = num_rails_p'(1);
                end
            end

            PWR_UP_PG: begin
                // A rail that shows power-good on the timeout cycle still
                // passes; the timeout only fires while pgood is missing.
                if (!w_pg_cur && w_timeout_hit) begin
                    w_state_n      = PWR_FAULT;
                    w_rail_en_n    = '0;
                    w_fault_rail_n = r_idx;
                    w_cnt_n        = '0;
                end else if (!power_on_req_i) begin
                    // Abort: the rail currently being ramped is the first
                    // one to be dropped.
                    w_state_n          = PWR_DOWN;
                    w_cnt_n            = '0;
                    w_rail_en_n[r_idx] = 1'b0;
                end else if (w_pg_cur) begin
                    w_state_n = PWR_UP_SETTLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end

            PWR_UP_SETTLE: begin
                if (!power_on_req_i) begin
                    w_state_n          = PWR_DOWN;
                    w_cnt_n            = '0;
                    w_rail_en_n[r_idx] = 1'b0;
                end else if (w_delay_hit) begin
                    w_cnt_n = '0;
                    if (w_last_rail) begin
                        w_state_n = PWR_ON;
                    end else begin
                        w_state_n              = PWR_UP_PG;
                        w_idx_n                = w_idx_inc;
                        w_rail_en_n[w_idx_inc] = 1'b1;
                    end
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end

            PWR_ON: begin
                if (w_any_low) begin
                    w_state_n      = PWR_FAULT;
                    w_rail_en_n    = '0;
                    w_fault_rail_n = w_low_idx;
                end else if (override_i) begin
                    w_state_n   = PWR_OVR;
                    w_rail_en_n = override_en_i;
                end else if (!power_on_req_i) begin
                    w_state_n               = PWR_DOWN;
                    w_idx_n                 = c_last_idx;
                    w_cnt_n                 = '0;
                    w_rail_en_n[c_last_idx] = 1'b0;
                end
            end

            PWR_DOWN: begin
                // Requests are deliberately not looked at here: a power-down
                // always runs to completion before anything else starts.
                if (w_delay_hit) begin
                    w_cnt_n = '0;
                    if (w_first_rail) begin
                        w_state_n   = PWR_OFF;
                        w_rail_en_n = '0;
                    end else begin
                        w_idx_n                = w_idx_dec;
                        w_rail_en_n[w_idx_dec] = 1'b0;
                    end
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end

            PWR_FAULT: begin
                // Clearing while power is still requested would immediately
                // re-ramp into the same fault, so it is held off until
                // software drops the request.
                w_rail_en_n = '0;
                if (fault_clr_i && !power_on_req_i) begin
                    w_state_n = PWR_OFF;
                    w_idx_n   = '0;
                    w_cnt_n   = '0;
                end
            end

            PWR_OVR: begin
                if (!override_i) begin
                    // Leave override through a full top-down sequence so
                    // every rail gets its discharge time, even those the
                    // CPU already switched off.
                    w_state_n               = PWR_DOWN;
                    w_idx_n                 = c_last_idx;
                    w_cnt_n                 = '0;
                    w_rail_en_n[c_last_idx] = 1'b0;
                end else begin
                    w_rail_en_n = override_en_i;
                end
            end

            default: begin
                w_state_n   = PWR_OFF;
                w_idx_n     = '0;
                w_cnt_n     = '0;
                w_rail_en_n = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Status flags are decoded from the next
    // state so they change on the same edge that enters the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= PWR_OFF;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_rail_en    <= '0;
            r_fault_rail <= '0;
            r_busy       <= 1'b0;
            r_all_on     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_idx        <= w_idx_n;
            r_cnt        <= w_cnt_n;
            r_rail_en    <= w_rail_en_n;
            r_fault_rail <= w_fault_rail_n;
            r_busy       <= (w_state_n == PWR_UP_PG)     ||
                            (w_state_n == PWR_UP_SETTLE) ||
                            (w_state_n == PWR_DOWN);
            r_all_on     <= (w_state_n == PWR_ON);
            r_fault      <= (w_state_n == PWR_FAULT);
        end
    end

    assign rail_en_o    = r_rail_en;
    assign busy_o       = r_busy;
    assign all_on_o     = r_all_on;
    assign fault_o      = r_fault;
    assign fault_rail_o = r_fault_rail;

endmodule : bsg_gateway_power_seq
`default_nettype wire

// File: tb/tb_bsg_gateway_power_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_gateway_power_seq
//  Description : Self-checking bench for bsg_gateway_power_seq (3 rails).
//                Expected enables and flags come from cycle-count formulas
//                derived from the sequencing rules; power-good is modelled
//                as each enable echoed back after a programmable lag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_gateway_power_seq;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        power_on_req_i;
    logic [2:0]  pgood_i;
    logic [15:0] delay_i;
    logic [15:0] timeout_i;
    logic        override_i;
    logic [2:0]  override_en_i;
    logic        fault_clr_i;
    logic [2:0]  rail_en_o;
    logic        busy_o;
    logic        all_on_o;
    logic        fault_o;
    logic [1:0]  fault_rail_o;

    always #5 clk = ~clk;

    bsg_gateway_power_seq #(
        .num_rails_p    (3),
        .cnt_width_p    (16)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .power_on_req_i (power_on_req_i),
        .pgood_i        (pgood_i),
        .delay_i        (delay_i),
        .timeout_i      (timeout_i),
        .override_i     (override_i),
        .override_en_i  (override_en_i),
        .fault_clr_i    (fault_clr_i),
        .rail_en_o      (rail_en_o),
        .busy_o         (busy_o),
        .all_on_o       (all_on_o),
        .fault_o        (fault_o),
        .fault_rail_o   (fault_rail_o)
    );

    // Board model: each rail's power-good follows its enable, delayed by
    // 'lag' extra cycles; 'kill' forces selected power-goods low.
    logic [2:0] pg_hist [0:3];
    logic [1:0] lag;
    logic [2:0] kill;

    always @(negedge clk) begin
        if (!reset_n_i) begin
            for (int k = 0; k < 4; k++) pg_hist[k] <= 3'b000;
        end else begin
            for (int k = 3; k > 0; k--) pg_hist[k] <= pg_hist[k-1];
            pg_hist[0] <= rail_en_o;
        end
    end

    assign pgood_i = pg_hist[lag] & ~kill;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Rail k is enabled k*(lag+4+delay) cycles after rail 0, which rises on
    // the first edge after the request: 3 edges of pgood reaction plus
    // delay+1 settle cycles per step.
    function automatic logic [2:0] up_en(input int c, input int d, input int j);
        logic [2:0] e;
        e = 3'b000;
        for (int k = 0; k < 3; k++)
            if (c >= 1 + k * (j + 4 + d)) e[k] = 1'b1;
        return e;
    endfunction

    // During a top-down power-off, rail k drops (2-k)*(delay+1) cycles
    // after the first edge.
    function automatic logic [2:0] down_en(input int c, input int d, input logic [2:0] start);
        logic [2:0] e;
        e = start;
        for (int k = 0; k < 3; k++)
            if (c >= 1 + (2 - k) * (d + 1)) e[k] = 1'b0;
        return e;
    endfunction

    task automatic ramp_up(input int d, input int j);
        int t_on;
        delay_i        = 16'(d);
        timeout_i      = 16'd0;
        lag            = 2'(j);
        power_on_req_i = 1'b1;
        t_on = 1 + 3 * (j + 4 + d);
        for (int c = 1; c <= t_on + 1; c++) begin
            tick();
            check("up_en",     rail_en_o, up_en(c, d, j));
            check("up_busy",   busy_o,    c < t_on);
            check("up_all_on", all_on_o,  c >= t_on);
            check("up_fault",  fault_o,   1'b0);
        end
    endtask

    task automatic ramp_down_from(input int d, input logic [2:0] start);
        int total;
        total = 1 + 3 * (d + 1);
        for (int c = 1; c <= total + 1; c++) begin
            tick();
            check("dn_en",     rail_en_o, down_en(c, d, start));
            check("dn_busy",   busy_o,    c < total);
            check("dn_all_on", all_on_o,  1'b0);
        end
        idle(5);
    endtask

    initial begin
        int d, j, to, ca, t1, f, total;
        logic [2:0] last;

        reset_n_i      = 1'b0;
        power_on_req_i = 1'b0;
        delay_i        = 16'd0;
        timeout_i      = 16'd0;
        override_i     = 1'b0;
        override_en_i  = 3'b000;
        fault_clr_i    = 1'b0;
        lag            = 2'd0;
        kill           = 3'b000;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_en",         rail_en_o,    3'b000);
        check("rst_busy",       busy_o,       1'b0);
        check("rst_all_on",     all_on_o,     1'b0);
        check("rst_fault",      fault_o,      1'b0);
        check("rst_fault_rail", fault_rail_o, 2'd0);
        reset_n_i = 1'b1;
        idle(5);
        check("idle_en",   rail_en_o, 3'b000);
        check("idle_busy", busy_o,    1'b0);

        // Reference sequence: delay 4, pgood 2 cycles after each enable
        ramp_up(4, 2);
        power_on_req_i = 1'b0;
        ramp_down_from(4, 3'b111);

        // Randomized up/down ramps
        for (int it = 0; it < 3; it++) begin
            d = $urandom_range(0, 6);
            j = $urandom_range(0, 3);
            ramp_up(d, j);
            power_on_req_i = 1'b0;
            ramp_down_from(d, 3'b111);
        end

        // Abort during rail 1 settle
        d  = $urandom_range(1, 5);
        j  = $urandom_range(0, 3);
        t1 = 1 + (j + 4 + d);
        ca = t1 + j + 3 + $urandom_range(0, d);
        delay_i = 16'(d); timeout_i = 16'd0; lag = 2'(j);
        power_on_req_i = 1'b1;
        for (int c = 1; c <= ca; c++) begin
            tick();
            check("ab_up_en", rail_en_o, up_en(c, d, j));
        end
        power_on_req_i = 1'b0;
        total = 1 + 2 * (d + 1);
        for (int c = 1; c <= total + 1; c++) begin
            tick();
            check("ab_en",   rail_en_o, {2'b00, c < 1 + (d + 1)});
            check("ab_busy", busy_o,    c < total);
        end
        idle(5);

        // Brown-out on rails 2 and 0 together while ON
        d = $urandom_range(0, 4);
        j = $urandom_range(0, 3);
        ramp_up(d, j);
        kill = 3'b101;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("bo_fault", fault_o, c >= 3);
            check("bo_all_on", all_on_o, c < 3);
            check("bo_en", rail_en_o, (c >= 3) ? 3'b000 : 3'b111);
        end
        check("bo_fault_rail", fault_rail_o, 2'd0);
        power_on_req_i = 1'b0;
        fault_clr_i    = 1'b1;
        tick();
        check("bo_clr_fault", fault_o, 1'b0);
        fault_clr_i = 1'b0;
        kill        = 3'b000;
        idle(5);

        // Power-good timeout on rail 1
        d  = $urandom_range(0, 4);
        j  = $urandom_range(0, 3);
        to = j + 2 + $urandom_range(0, 6);
        t1 = 1 + (j + 4 + d);
        f  = t1 + to + 1;
        kill = 3'b010;
        delay_i = 16'(d); timeout_i = 16'(to); lag = 2'(j);
        power_on_req_i = 1'b1;
        for (int c = 1; c <= f + 1; c++) begin
            tick();
            check("to_en",    rail_en_o, (c < f) ? (up_en(c, d, j) & 3'b011) : 3'b000);
            check("to_fault", fault_o,   c >= f);
            check("to_busy",  busy_o,    c < f);
        end
        check("to_fault_rail", fault_rail_o, 2'd1);
        fault_clr_i = 1'b1;
        idle(2);
        check("to_clr_ignored", fault_o, 1'b1);
        power_on_req_i = 1'b0;
        tick();
        check("to_clr_fault", fault_o,      1'b0);
        check("to_clr_busy",  busy_o,       1'b0);
        check("to_clr_rail",  fault_rail_o, 2'd1);
        fault_clr_i = 1'b0;
        kill        = 3'b000;
        timeout_i   = 16'd0;
        idle(5);

        // Override from ON; power-good ignored; release runs full power-down
        d = $urandom_range(0, 4);
        j = $urandom_range(0, 3);
        ramp_up(d, j);
        override_i    = 1'b1;
        override_en_i = 3'b101;
        tick();
        check("ovr_en0",     rail_en_o, 3'b101);
        check("ovr_all_on",  all_on_o,  1'b0);
        check("ovr_busy",    busy_o,    1'b0);
        power_on_req_i = 1'b0;
        kill           = 3'b111;
        for (int i = 0; i < 6; i++) begin
            override_en_i = 3'($urandom_range(0, 7));
            tick();
            check("ovr_en",    rail_en_o, override_en_i);
            check("ovr_fault", fault_o,   1'b0);
        end
        last       = override_en_i;
        override_i = 1'b0;
        ramp_down_from(d, last);
        kill = 3'b000;
        check("ovr_done_fault", fault_o, 1'b0);

        // Asynchronous reset in the middle of a power-down
        ramp_up(2, 0);
        power_on_req_i = 1'b0;
        idle(2);
        check("ar_pre_busy", busy_o, 1'b1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("ar_en",         rail_en_o,    3'b000);
        check("ar_busy",       busy_o,       1'b0);
        check("ar_fault_rail", fault_rail_o, 2'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        idle(6);
        check("ar_post_en",     rail_en_o, 3'b000);
        check("ar_post_busy",   busy_o,    1'b0);
        check("ar_post_all_on", all_on_o,  1'b0);
        ramp_up(1, 1);
        power_on_req_i = 1'b0;
        ramp_down_from(1, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bsg_gateway_power_seq
`default_nettype wire
